// File: rtl/dsm_nbit_quant.sv
// rtl/dsm_nbit_quant.sv - error-feedback delta-sigma requantiser, first/second-order NTF, overload counter
module dsm_nbit_quant #(
    parameter int DATA_W   = 16,
    parameter int OUT_BITS = 2,
    parameter int CNT_W    = 16
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic signed [DATA_W-1:0]   x_in,
    input  logic                       order_sel,
    input  logic                       clr_cnt,
    output logic                       out_valid,
    output logic signed [OUT_BITS-1:0] code_out,
    output logic signed [DATA_W-1:0]   y_out,
    output logic                       ovl,
    output logic [CNT_W-1:0]           ovl_cnt
);

    localparam int IW = DATA_W + 3;
    localparam int SH = DATA_W - OUT_BITS;

    localparam logic signed [IW-1:0] STEP   = IW'(2 ** SH);
    localparam logic signed [IW-1:0] HALF   = IW'(2 ** (SH - 1));
    localparam logic signed [IW-1:0] CMAX   = IW'(2 ** (OUT_BITS - 1) - 1);
    localparam logic signed [IW-1:0] CMIN   = -CMAX - IW'(1);
    localparam logic signed [IW-1:0] NSTEP  = -STEP;

    logic signed [IW-1:0]       e1_q, e2_q;
    logic signed [IW-1:0]       x_ext, u_d, c_raw, code_w, y_w, err_w, err_d;
    logic signed [OUT_BITS-1:0] code_q, code_d;
    logic signed [DATA_W-1:0]   y_q, y_d;
    logic                       ovl_q, ovl_d, out_valid_q;
    logic [CNT_W-1:0]           cnt_q;

    always_comb begin
        x_ext = {{3{x_in[DATA_W-1]}}, x_in};
        if (order_sel)
            u_d = x_ext + (e1_q <<< 1) - e2_q;
        else
            u_d = x_ext + e1_q;

        // Mid-rise quantiser: floor division by STEP, then clamp to the code range.
        c_raw = u_d >>> SH;
        if (c_raw > CMAX)
            code_w = CMAX;
        else if (c_raw < CMIN)
            code_w = CMIN;
        else
            code_w = c_raw;

        y_w   = (code_w <<< SH) + HALF;
        err_w = u_d - y_w;

        // Bounded error keeps the loop from winding up during sustained overload.
        if (err_w > STEP)
            err_d = STEP;
        else if (err_w < NSTEP)
            err_d = NSTEP;
        else
            err_d = err_w;

        code_d = code_w[OUT_BITS-1:0];
        y_d    = y_w[DATA_W-1:0];
        ovl_d  = (c_raw != code_w);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            e1_q        <= '0;
            e2_q        <= '0;
            code_q      <= '0;
            y_q         <= '0;
            ovl_q       <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                code_q <= code_d;
                y_q    <= y_d;
                ovl_q  <= ovl_d;
                e2_q   <= e1_q;
                e1_q   <= err_d;
            end
            if (clr_cnt)
                cnt_q <= '0;
            else if (in_valid && ovl_d && (cnt_q != '1))
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign out_valid = out_valid_q;
    assign code_out  = code_q;
    assign y_out     = y_q;
    assign ovl       = ovl_q;
    assign ovl_cnt   = cnt_q;

endmodule

// File: tb/tb_dsm_nbit_quant.sv
// tb/tb_dsm_nbit_quant.sv - directed self-checking bench for dsm_nbit_quant
module tb_dsm_nbit_quant;

    logic               CLK = 1'b0;
    logic               reset;
    logic               in_valid;
    logic signed [15:0] x_in;
    logic               order_sel;
    logic               clr_cnt;

    logic               out_valid, out_valid4;
    logic signed [1:0]  code_out, code_out4;
    logic signed [15:0] y_out, y_out4;
    logic               ovl, ovl4;
    logic [15:0]        ovl_cnt;
    logic [3:0]         ovl_cnt4;

    int total = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    dsm_nbit_quant dut (
        .CLK(CLK), .reset(reset), .in_valid(in_valid), .x_in(x_in),
        .order_sel(order_sel), .clr_cnt(clr_cnt), .out_valid(out_valid),
        .code_out(code_out), .y_out(y_out), .ovl(ovl), .ovl_cnt(ovl_cnt)
    );

    dsm_nbit_quant #(.DATA_W(16), .OUT_BITS(2), .CNT_W(4)) dut4 (
        .CLK(CLK), .reset(reset), .in_valid(in_valid), .x_in(x_in),
        .order_sel(order_sel), .clr_cnt(clr_cnt), .out_valid(out_valid4),
        .code_out(code_out4), .y_out(y_out4), .ovl(ovl4), .ovl_cnt(ovl_cnt4)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input int x, input logic ord, input logic clr);
        in_valid  = v;
        x_in      = 16'(x);
        order_sel = ord;
        clr_cnt   = clr;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    int exp_code1 [4] = '{0, -1, -1, 0};
    int ec;
    int last_code;

    initial begin
        reset = 1'b1; in_valid = 1'b0; x_in = '0; order_sel = 1'b0; clr_cnt = 1'b0;
        @(posedge CLK); #1;
        step(1'b0, 0, 1'b0, 1'b0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_code", code_out, 0);
        chk("rst_y", y_out, 0);
        chk("rst_ovl", ovl, 0);
        chk("rst_cnt", ovl_cnt, 0);
        chk("rst_cnt4", ovl_cnt4, 0);
        reset = 1'b0;

        // first order, zero input: 0,-1 limit cycle
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 0, 1'b0, 1'b0);
            ec = (i % 2 == 0) ? 0 : -1;
            chk("o1_code", code_out, ec);
            chk("o1_y", y_out, (ec == 0) ? 8192 : -8192);
            chk("o1_valid", out_valid, 1);
            chk("o1_ovl", ovl, 0);
        end
        step(1'b0, 0, 1'b0, 1'b0);
        chk("idle_valid", out_valid, 0);
        chk("idle_code_hold", code_out, -1);
        chk("idle_y_hold", y_out, -8192);

        // second order, zero input: 0,-1,-1,0
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 0, 1'b1, 1'b0);
            ec = exp_code1[i % 4];
            chk("o2_code", code_out, ec);
            chk("o2_y", y_out, (ec == 0) ? 8192 : -8192);
            chk("o2_ovl", ovl, 0);
        end

        // second order with valid every third cycle
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 0, 1'b1, 1'b0);
            ec = exp_code1[i % 4];
            chk("gap_code", code_out, ec);
            chk("gap_valid", out_valid, 1);
            for (int j = 0; j < 2; j++) begin
                step(1'b0, 12345, 1'b1, 1'b0);
                chk("gap_idle_valid", out_valid, 0);
                chk("gap_hold_code", code_out, ec);
                chk("gap_hold_y", y_out, (ec == 0) ? 8192 : -8192);
            end
        end

        // sustained overload, first order, x = 32767
        do_reset();
        step(1'b1, 32767, 1'b0, 1'b0);
        chk("ov1_code", code_out, 1);
        chk("ov1_y", y_out, 24576);
        chk("ov1_ovl", ovl, 0);
        chk("ov1_cnt", ovl_cnt, 0);
        for (int s = 2; s <= 20; s++) begin
            step(1'b1, 32767, 1'b0, 1'b0);
            chk("ov_code", code_out, 1);
            chk("ov_y", y_out, 24576);
            chk("ov_ovl", ovl, 1);
            chk("ov_cnt", ovl_cnt, s - 1);
            chk("ov_cnt4", ovl_cnt4, (s - 1 > 15) ? 15 : s - 1);
        end
        chk("ov_cnt4_sat", ovl_cnt4, 15);

        // clear wins over a simultaneous increment
        step(1'b1, 32767, 1'b0, 1'b1);
        chk("clr_ovl", ovl, 1);
        chk("clr_cnt", ovl_cnt, 0);
        chk("clr_cnt4", ovl_cnt4, 0);
        step(1'b1, 32767, 1'b0, 1'b0);
        chk("post_clr_cnt", ovl_cnt, 1);

        // mid-stream reset with live error history and in_valid high
        reset = 1'b1;
        step(1'b1, 32767, 1'b0, 1'b0);
        reset = 1'b0;
        chk("mrst_valid", out_valid, 0);
        chk("mrst_code", code_out, 0);
        chk("mrst_y", y_out, 0);
        chk("mrst_ovl", ovl, 0);
        chk("mrst_cnt", ovl_cnt, 0);
        step(1'b1, 0, 1'b0, 1'b0);
        chk("cold_code", code_out, 0);
        chk("cold_y", y_out, 8192);
        chk("cold_ovl", ovl, 0);
        step(1'b1, 0, 1'b0, 1'b0);
        last_code = code_out;
        chk("cold_code2", last_code, -1);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
